// File: rtl/debounce_sync.sv
// Input conditioner: brings a bouncy asynchronous input into the clk_i domain,
// accepts a new level only after DEBOUNCE_CYCLES consecutive agreeing samples.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic noisy_i,
  input  logic en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic pending_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_LOW2HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_HIGH2LOW = 2'd3
  } state_e;

  localparam state_e ST_RESET = RESET_LEVEL ? ST_HIGH : ST_LOW;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("debounce_sync: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d, pending_d;

  // Synchroniser chain; keeps running even while the filter is disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Qualification: any disagreeing sample or disable restarts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (en_i && sync_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_LOW2HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_LOW2HIGH: begin
        if (!en_i || !sync_s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (en_i && !sync_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_HIGH2LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_HIGH2LOW: begin
        if (!en_i || sync_s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the next state; edge pulses compare against the held level.
  always_comb begin
    level_d   = (state_d == ST_HIGH) || (state_d == ST_HIGH2LOW);
    pending_d = (state_d == ST_LOW2HIGH) || (state_d == ST_HIGH2LOW);
    rise_d    = level_d && !level_o;
    fall_d    = !level_d && level_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_o   <= RESET_LEVEL;
      rise_o    <= 1'b0;
      fall_o    <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      level_o   <= level_d;
      rise_o    <= rise_d;
      fall_o    <= fall_d;
      pending_o <= pending_d;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: four parameterisations checked against a run-length
// reference model, plus directed vectors for latency, bounce, enable and reset.
module tb_debounce_sync;

  localparam int N = 4;
  localparam int MS [N] = '{2, 2, 3, 2};
  localparam int MD [N] = '{16, 4, 1, 4};
  localparam bit MR [N] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] noisy = '0;
  logic [N-1:0] en = '0;
  wire  [N-1:0] level, rise, fall, pending;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(1'b0)) u_dflt (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy[0]), .en_i(en[0]),
    .level_o(level[0]), .rise_o(rise[0]), .fall_o(fall[0]), .pending_o(pending[0]));
  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) u_d4 (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy[1]), .en_i(en[1]),
    .level_o(level[1]), .rise_o(rise[1]), .fall_o(fall[1]), .pending_o(pending[1]));
  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) u_d1 (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy[2]), .en_i(en[2]),
    .level_o(level[2]), .rise_o(rise[2]), .fall_o(fall[2]), .pending_o(pending[2]));
  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) u_rl1 (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy[3]), .en_i(en[3]),
    .level_o(level[3]), .rise_o(rise[3]), .fall_o(fall[3]), .pending_o(pending[3]));

  int checks = 0;
  int passed = 0;
  int n_rise = 0;
  int n_fall = 0;
  int hold [N];

  // Reference model: delayed sample history plus a run length of disagreeing samples.
  bit m_level [N];
  int m_run   [N];
  bit m_rise  [N];
  bit m_fall  [N];
  bit m_hist  [N][8];

  typedef struct {
    logic noisy;
    logic level;
    logic rise;
    logic fall;
    logic pending;
  } vec_t;
  vec_t tv [6];

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_level[i] = MR[i];
      m_run[i]   = 0;
      m_rise[i]  = 1'b0;
      m_fall[i]  = 1'b0;
      for (int k = 0; k < 8; k++) m_hist[i][k] = MR[i];
    end
  endfunction

  function automatic void model_edge();
    bit s;
    for (int i = 0; i < N; i++) begin
      s = m_hist[i][MS[i]-1];
      for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = noisy[i];
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (en[i] && (s != m_level[i])) begin
        m_run[i]++;
        if (m_run[i] == MD[i]) begin
          m_level[i] = s;
          m_run[i]   = 0;
          m_rise[i]  = s;
          m_fall[i]  = !s;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d level", i), level[i], m_level[i]);
      check($sformatf("u%0d rise", i), rise[i], m_rise[i]);
      check($sformatf("u%0d fall", i), fall[i], m_fall[i]);
      check($sformatf("u%0d pending", i), pending[i], (m_run[i] != 0));
    end
  endtask

  // One clock: model advances with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_edge();
    check_all();
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst level dflt", level[0], 1'b0);
    check("rst level rl1", level[3], 1'b1);
    check("rst rise dflt", rise[0], 1'b0);
    check("rst fall rl1", fall[3], 1'b0);
    check("rst pending rl1", pending[3], 1'b0);
    check_all();
    step();
    #2 rst = 1'b0;
    en = '1;

    // Single-clock pulse through SYNC_STAGES=3, DEBOUNCE_CYCLES=1.
    n_rise = 0;
    n_fall = 0;
    for (int k = 0; k < 6; k++) begin
      noisy[2] = tv[k].noisy;
      step();
      check($sformatf("tv%0d level", k), level[2], tv[k].level);
      check($sformatf("tv%0d rise", k), rise[2], tv[k].rise);
      check($sformatf("tv%0d fall", k), fall[2], tv[k].fall);
      check($sformatf("tv%0d pending", k), pending[2], tv[k].pending);
      n_rise += int'(rise[2]);
      n_fall += int'(fall[2]);
    end
    check_int("d1 rise count", n_rise, 1);
    check_int("d1 fall count", n_fall, 1);

    // Bounce on DEBOUNCE_CYCLES=4: the first burst must not qualify.
    n_rise = 0;
    for (int k = 1; k <= 14; k++) begin
      noisy[1] = (k == 4) ? 1'b0 : 1'b1;
      step();
      check($sformatf("bounce level e%0d", k), level[1], (k >= 10));
      n_rise += int'(rise[1]);
    end
    check_int("bounce rise count", n_rise, 1);

    // Clean rise with defaults.
    noisy[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 2) check("rise pending e2", pending[0], 1'b0);
      if (k == 3) check("rise pending e3", pending[0], 1'b1);
      if (k == 17) check("rise level e17", level[0], 1'b0);
      if (k == 18) begin
        check("rise level e18", level[0], 1'b1);
        check("rise pulse e18", rise[0], 1'b1);
      end
      if (k == 19) check("rise pulse e19", rise[0], 1'b0);
    end

    // Fall interrupted by en_i, then resumed.
    noisy[0] = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    check("fall pending before disable", pending[0], 1'b1);
    en[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("disabled pending %0d", k), pending[0], 1'b0);
      check($sformatf("disabled level %0d", k), level[0], 1'b1);
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        check("resume level e15", level[0], 1'b1);
        check("resume fall e15", fall[0], 1'b0);
      end
      if (k == 16) begin
        check("resume level e16", level[0], 1'b0);
        check("resume fall e16", fall[0], 1'b1);
      end
    end

    // Reset while qualifying a rise with cnt=10.
    noisy[0] = 1'b1;
    for (int k = 1; k <= 12; k++) step();
    check("midqual pending", pending[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst pending", pending[0], 1'b0);
    check("midrst level", level[0], 1'b0);
    check("midrst rise", rise[0], 1'b0);
    noisy[0] = 1'b0;
    step();
    #2 rst = 1'b0;
    n_rise = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_rise += int'(rise[0]);
    end
    check_int("post reset rise count", n_rise, 0);

    // Randomised run-length stimulus against the model.
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          noisy[i] = 1'($urandom_range(0, 1));
          hold[i]  = $urandom_range(1, 2 * MD[i] + 4);
        end else begin
          hold[i]--;
        end
        en[i] = ($urandom_range(0, 31) != 0);
      end
      step();
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Input conditioner that feeds the D input of the team's transparent latch (d_i) from an asynchronous, bouncy source such as a switch or an external pin.
- Synchronises the raw input into the clk_i domain through a flop chain.
- Filters bounce with a consecutive-sample counter and FSM.
- Outputs a clean level plus single-cycle rise/fall pulses.
- level_o is the signal that drives the latch's d_i.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
DEBOUNCE_CYCLES, 16, consecutive differing synchronised samples needed to accept a new level; legal range >= 1.
RESET_LEVEL, 1'b0, value loaded into the synchroniser chain and level_o on reset.

Ports:
clk_i  input  1  single system clock, rising-edge.
rst_i  input  1  reset, asynchronous, active-high.
noisy_i  input  1  raw asynchronous input.
en_i  input  1  filter enable; 0 freezes acceptance of new levels.
level_o  output  1  debounced level; drives the latch's d_i.
rise_o  output  1  1-cycle pulse when level_o goes 0->1.
fall_o  output  1  1-cycle pulse when level_o goes 1->0.
pending_o  output  1  high while a level change is being qualified.

Behaviour:
- Reset (rst_i=1, takes effect immediately, no clock needed):
  - All sync flops = RESET_LEVEL; level_o = RESET_LEVEL.
  - rise_o = fall_o = pending_o = 0; counter = 0.
  - FSM = ST_LOW if RESET_LEVEL=0, else ST_HIGH.
- Synchroniser: shift chain of SYNC_STAGES flops, always clocking regardless of en_i. s denotes the last stage output.
- Counter width: $clog2(DEBOUNCE_CYCLES+1); it never exceeds DEBOUNCE_CYCLES-1.
- FSM states: ST_LOW, ST_LOW2HIGH, ST_HIGH, ST_HIGH2LOW. Per rising edge:
  - ST_LOW: if en_i && s=1 -> ST_LOW2HIGH, cnt=1. Exception: if DEBOUNCE_CYCLES=1, go directly to ST_HIGH with level_o=1 and a rise_o pulse.
  - ST_LOW2HIGH:
    - s=0 or en_i=0 -> ST_LOW, cnt=0.
    - s=1 and cnt=DEBOUNCE_CYCLES-1 -> ST_HIGH, level_o=1, rise_o=1, cnt=0.
    - Otherwise cnt+1.
  - ST_HIGH and ST_HIGH2LOW: mirror images with s=0 and fall_o.
- pending_o = 1 exactly in ST_LOW2HIGH and ST_HIGH2LOW (registered state decode).
- rise_o and fall_o are registered, high for exactly the one cycle following the edge on which level_o changes, and never both high.
- Latency: noisy_i held stable at the new value. Number edges so that edge 1 is the first edge at which the first sync flop samples it. level_o changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults).
- Bounce: any sample of s equal to level_o while pending aborts qualification. The counter restarts from 0; there is no partial credit.
- en_i=0: any pending qualification aborts; level_o holds; the synchroniser keeps running. When en_i returns to 1, qualification starts fresh from the next edge.
- Reset mid-qualification: immediate return to reset values. No pulse is emitted.
- Glitch shorter than one clock may be missed by the synchroniser; that is acceptable.

Test Plan:
1. Reset check: rst_i=1 with RESET_LEVEL=0 -> level_o=0, rise_o=fall_o=pending_o=0, immediately and without a clock edge. Repeat with RESET_LEVEL=1 -> level_o=1.
2. Clean rise, defaults: noisy_i 0->1 and held -> pending_o goes high after edge 3; level_o=1 and rise_o=1 after edge 18; rise_o=0 after edge 19.
3. Bounce, DEBOUNCE_CYCLES=4: noisy_i=1 for 3 cycles, 0 for 1 cycle, then 1 held -> no rise_o during the first burst. level_o rises exactly 4 qualified samples after s returns to 1. Exactly one rise_o pulse in total.
4. Fall with en_i gating: level_o=1, noisy_i->0, en_i dropped to 0 after 5 pending cycles -> pending_o=0 and level_o stays 1. Raise en_i -> fall_o pulses DEBOUNCE_CYCLES edges later.
5. Reset mid-qualification: with cnt=10 in ST_LOW2HIGH, assert rst_i between clock edges -> outputs return to reset values at once; no rise_o after release while noisy_i=0.
6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3: a single-cycle noisy_i pulse of width 1 clock -> level_o toggles 1 then 0 on consecutive cycles, with both rise_o and fall_o seen once each.
